car_collision: RTL and testbench

Downstream consumer of the car-movement block's eight 10-bit car positions. Once per video frame it snapshots all car positions and the frog position, then scans the eight cars one per clock against the frog's bounding box. It reports a single-cycle hit pulse with the lowest-numbered colliding car, and enforces a post-hit grace period so that one collision cannot trigger repeated deaths. It feeds the game-state/lives logic.

---
 rtl/car_collision.sv | 136 +++++++++++++
 tb/tb_car_collision.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/car_collision.sv
// car_collision: per-frame snapshot of eight car positions and the frog, scanned one car per clock for bounding-box overlap.
// Latency: strobe in cycle T, scan T+1..T+8, one-cycle o_hit in T+9, IDLE again in T+10; outputs come straight from registers.
// Backpressure: none; strobes outside IDLE only age the grace counter. Option CAR_WRAP_COLLISION_EN: modulo-1024 horizontal test.
module car_collision #(
    parameter int LANE_Y0      = 64,
    parameter int LANE_PITCH   = 48,
    parameter int CAR_W        = 32,
    parameter int CAR_H        = 32,
    parameter int FROG_W       = 32,
    parameter int FROG_H       = 32,
    parameter int GRACE_FRAMES = 60
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       i_frame_start,
    input  logic [9:0] car_x1,
    input  logic [9:0] car_x2,
    input  logic [9:0] car_x3,
    input  logic [9:0] car_x4,
    input  logic [9:0] car_x5,
    input  logic [9:0] car_x6,
    input  logic [9:0] car_x7,
    input  logic [9:0] car_x8,
    input  logic [9:0] frog_x,
    input  logic [9:0] frog_y,
    output logic       o_hit,
    output logic [2:0] o_hit_car,
    output logic       o_busy,
    output logic       o_grace
);

    localparam int GW = (GRACE_FRAMES < 2) ? 1 : $clog2(GRACE_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t        state;
    logic [2:0]    idx;
    logic          found;
    logic [2:0]    found_idx;
    logic [9:0]    snap_car [8];
    logic [9:0]    snap_fx;
    logic [9:0]    snap_fy;
    logic [GW-1:0] grace_cnt;

    logic [10:0]   lane_y;
    logic [9:0]    cur_car;
    logic          v_hit;
    logic          h_hit;
    logic          hit_now;
    logic [GW-1:0] grace_dec;

    // Overlap test of the car selected by idx against the snapshotted frog box.
    always_comb begin
        cur_car = snap_car[idx];
        lane_y  = 11'(LANE_Y0) + 11'(idx) * 11'(LANE_PITCH);
        v_hit   = ({1'b0, snap_fy} < lane_y + 11'(CAR_H)) &&
                  (lane_y < {1'b0, snap_fy} + 11'(FROG_H));
`ifdef CAR_WRAP_COLLISION_EN
        // Distances taken mod 1024 so a car straddling the wrap point still collides.
        h_hit   = ({1'b0, 10'(snap_fx - cur_car)} < 11'(CAR_W)) ||
                  ({1'b0, 10'(cur_car - snap_fx)} < 11'(FROG_W));
`else
        h_hit   = ({1'b0, cur_car} < {1'b0, snap_fx} + 11'(FROG_W)) &&
                  ({1'b0, snap_fx} < {1'b0, cur_car} + 11'(CAR_W));
`endif
        hit_now = v_hit && h_hit;
        // Grace value that will be current during REPORT, after any strobe this cycle.
        grace_dec = (i_frame_start && grace_cnt != '0) ? grace_cnt - 1'b1 : grace_cnt;
    end

    // Scan FSM, grace counter and registered hit outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            idx       <= '0;
            found     <= 1'b0;
            found_idx <= '0;
            snap_fx   <= '0;
            snap_fy   <= '0;
            for (int i = 0; i < 8; i++) snap_car[i] <= '0;
            grace_cnt <= '0;
            o_hit     <= 1'b0;
            o_hit_car <= '0;
        end else begin
            o_hit <= 1'b0;
            if (i_frame_start && grace_cnt != '0)
                grace_cnt <= grace_cnt - 1'b1;
            case (state)
                IDLE: begin
                    if (i_frame_start) begin
                        snap_car[0] <= car_x1;
                        snap_car[1] <= car_x2;
                        snap_car[2] <= car_x3;
                        snap_car[3] <= car_x4;
                        snap_car[4] <= car_x5;
                        snap_car[5] <= car_x6;
                        snap_car[6] <= car_x7;
                        snap_car[7] <= car_x8;
                        snap_fx     <= frog_x;
                        snap_fy     <= frog_y;
                        idx         <= '0;
                        found       <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (!found && hit_now) begin
                        found     <= 1'b1;
                        found_idx <= idx;
                    end
                    if (idx == 3'd7) begin
                        state <= REPORT;
                        // Pulse is set up here so it is a register output during REPORT.
                        if ((found || hit_now) && grace_dec == '0) begin
                            o_hit     <= 1'b1;
                            o_hit_car <= found ? found_idx : idx;
                        end
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                REPORT: begin
                    // A reported hit reloads grace, overriding a same-cycle decrement.
                    if (o_hit)
                        grace_cnt <= GW'(GRACE_FRAMES);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_grace = (grace_cnt != '0);

endmodule

// File: tb/tb_car_collision.sv
module tb_car_collision;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       i_frame_start = 1'b0;
    logic [9:0] car_x [8];
    logic [9:0] frog_x = '0;
    logic [9:0] frog_y = '0;
    logic       o_hit;
    logic [2:0] o_hit_car;
    logic       o_busy;
    logic       o_grace;

    int tests  = 0;
    int failed = 0;

    always #5 CLK = ~CLK;

    car_collision #(.GRACE_FRAMES(3)) dut (
        .CLK(CLK), .RST(RST), .i_frame_start(i_frame_start),
        .car_x1(car_x[0]), .car_x2(car_x[1]), .car_x3(car_x[2]), .car_x4(car_x[3]),
        .car_x5(car_x[4]), .car_x6(car_x[5]), .car_x7(car_x[6]), .car_x8(car_x[7]),
        .frog_x(frog_x), .frog_y(frog_y),
        .o_hit(o_hit), .o_hit_car(o_hit_car), .o_busy(o_busy), .o_grace(o_grace)
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All cars parked far right, frog placed; callers then move individual cars.
    task automatic setup(input int fx, input int fy);
        for (int i = 0; i < 8; i++) car_x[i] = 10'd600;
        frog_x = 10'(fx);
        frog_y = 10'(fy);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        i_frame_start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("rst_hit",   o_hit,     0);
        check("rst_car",   o_hit_car, 0);
        check("rst_busy",  o_busy,    0);
        check("rst_grace", o_grace,   0);
    endtask

    // Strobe in cycle T, then observe T+1..T+10 at falling edges.
    // disturb: in T+3 move the live inputs off the hit and pulse a stray strobe.
    task automatic run_frame(input string tag, input bit exp_hit, input int exp_car,
                             input bit g1, input bit g10, input bit disturb);
        int pulses = 0;
        int hit_n  = 0;
        @(negedge CLK);
        i_frame_start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge CLK);
            i_frame_start = 1'b0;
            if (disturb && n == 3) begin
                for (int i = 0; i < 8; i++) car_x[i] = 10'd900;
                frog_x = 10'd300;
                i_frame_start = 1'b1;
            end
            if (o_hit) begin
                pulses++;
                hit_n = n;
                check({tag, "_car"}, o_hit_car, exp_car);
            end
            if (n == 1) begin
                check({tag, "_busy1"}, o_busy, 1);
                check({tag, "_grace1"}, o_grace, g1);
            end
            if (n == 9)  check({tag, "_busy9"}, o_busy, 1);
            if (n == 10) begin
                check({tag, "_busy10"}, o_busy, 0);
                check({tag, "_grace10"}, o_grace, g10);
            end
        end
        check({tag, "_pulses"}, pulses, exp_hit ? 1 : 0);
        if (exp_hit) check({tag, "_lat"}, hit_n, 9);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) car_x[i] = 10'd600;

        // Basic: car 3 lane at y=160 overlaps frog (100,160) at x=110.
        do_reset();
        setup(100, 160); car_x[2] = 10'd110;
        run_frame("basic", 1, 2, 0, 1, 0);

        // Right edge: 132 < 100+32 is false.
        do_reset();
        setup(100, 160); car_x[2] = 10'd132;
        run_frame("edge132", 0, 0, 0, 0, 0);
        setup(100, 160); car_x[2] = 10'd131;
        run_frame("edge131", 1, 2, 0, 1, 0);

        // Frog y 90..121 overlaps lanes 64..95 and 112..143: lowest car wins.
        do_reset();
        setup(100, 90); car_x[0] = 10'd100; car_x[1] = 10'd100;
        run_frame("multi", 1, 0, 0, 1, 0);

        // Snapshot holds: live inputs and a stray strobe mid-scan change nothing.
        do_reset();
        setup(100, 160); car_x[2] = 10'd110;
        run_frame("live", 1, 2, 0, 1, 1);

        // Grace of 3: loaded after frame 0; strobes of frames 1,2,3 take it 3->2->1->0,
        // so frames 1 and 2 are suppressed and frame 3 reports again.
        do_reset();
        setup(100, 160); car_x[2] = 10'd110;
        run_frame("grace_f0", 1, 2, 0, 1, 0);
        run_frame("grace_f1", 0, 0, 1, 1, 0);
        run_frame("grace_f2", 0, 0, 1, 1, 0);
        run_frame("grace_f3", 1, 2, 0, 1, 0);

        // Car at 1010 against frog at x=5: only the wrapping compare sees it.
        do_reset();
        setup(5, 64); car_x[0] = 10'd1010;
`ifdef CAR_WRAP_COLLISION_EN
        run_frame("wrap", 1, 0, 0, 1, 0);
`else
        run_frame("wrap", 0, 0, 0, 0, 0);
`endif

        // Reset in T+4 with a hit pending: no pulse, idle right after.
        do_reset();
        setup(100, 160); car_x[2] = 10'd110;
        begin
            int pulses = 0;
            @(negedge CLK);
            i_frame_start = 1'b1;
            for (int n = 1; n <= 14; n++) begin
                @(negedge CLK);
                i_frame_start = 1'b0;
                RST = (n == 4);
                if (o_hit) pulses++;
                if (n == 5) check("rstscan_busy", o_busy, 0);
            end
            check("rstscan_pulses", pulses, 0);
            check("rstscan_grace", o_grace, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
